// File: rtl/aes_host_if.sv
// aes_host_if: host word-bus front end that buffers key/message blocks, launches the AES core and streams results back
module aes_host_if #(
   parameter int DATA_W  = 32,
   parameter int BLOCK_W = 128
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               req,
   input  logic               rw,
   input  logic               addr,
   input  logic [DATA_W-1:0]  wdata,
   input  logic               wvalid,
   output logic               wready,
   output logic [DATA_W-1:0]  rdata,
   output logic               rvalid,
   input  logic               rready,
   output logic               busy,
   output logic               err,
   output logic               key_valid,
   output logic [BLOCK_W-1:0] core_msg,
   output logic [BLOCK_W-1:0] core_key,
   output logic               core_start,
   input  logic               core_done,
   input  logic [BLOCK_W-1:0] core_result
);
   localparam int NBEATS = BLOCK_W / DATA_W;
   localparam int CW = $clog2(NBEATS);
   localparam logic [CW-1:0] LAST = CW'(NBEATS - 1);
   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] WR_MSG  = 3'd1;
   localparam logic [2:0] WR_KEY  = 3'd2;
   localparam logic [2:0] RUN     = 3'd3;
   localparam logic [2:0] RD_LOAD = 3'd4;
   localparam logic [2:0] RD      = 3'd5;

   logic [2:0]         r_state;
   logic [CW-1:0]      r_cnt;
   logic [BLOCK_W-1:0] r_msg, r_key, r_res, r_out;
   logic               r_msg_valid, r_key_valid, r_res_valid, r_start, r_err;
   logic               w_last;
   logic [CW-1:0]      w_cnt_nxt;

   assign w_last     = r_cnt == LAST;
   assign w_cnt_nxt  = w_last ? '0 : r_cnt + 1'b1;
   assign wready     = r_state == WR_MSG || r_state == WR_KEY;
   assign rvalid     = r_state == RD;
   assign rdata      = r_out[BLOCK_W-1 -: DATA_W];
   assign busy       = r_state != IDLE;
   assign err        = r_err;
   assign key_valid  = r_key_valid;
   assign core_msg   = r_msg;
   assign core_key   = r_key;
   assign core_start = r_start;

   // Controller FSM with its buffers; start and err are registered single-cycle pulses
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_msg       <= '0;
         r_key       <= '0;
         r_res       <= '0;
         r_out       <= '0;
         r_msg_valid <= 1'b0;
         r_key_valid <= 1'b0;
         r_res_valid <= 1'b0;
         r_start     <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_start <= 1'b0;
         r_err   <= 1'b0;
         case (r_state)
            IDLE:
               if (req) begin
                  if (rw) begin
                     r_state <= addr ? WR_KEY : WR_MSG;
                     r_cnt   <= '0;
                     if (addr) r_key_valid <= 1'b0;
                     else r_msg_valid <= 1'b0;
                  end else if (r_res_valid) r_state <= RD_LOAD;
                  else r_err <= 1'b1;
               end else if (r_msg_valid && r_key_valid) begin
                  r_state <= RUN;
                  r_start <= 1'b1;
               end
            WR_MSG:
               if (wvalid) begin
                  r_msg <= {r_msg[BLOCK_W-DATA_W-1:0], wdata};
                  r_cnt <= w_cnt_nxt;
                  if (w_last) begin
                     r_msg_valid <= 1'b1;
                     r_state     <= r_key_valid ? RUN : IDLE;
                     r_start     <= r_key_valid;
                  end
               end
            WR_KEY:
               if (wvalid) begin
                  r_key <= {r_key[BLOCK_W-DATA_W-1:0], wdata};
                  r_cnt <= w_cnt_nxt;
                  if (w_last) begin
                     r_key_valid <= 1'b1;
                     r_state     <= IDLE;
                  end
               end
            RUN:
               if (core_done) begin
                  r_res       <= core_result;
                  r_res_valid <= 1'b1;
                  r_msg_valid <= 1'b0;
                  r_state     <= IDLE;
               end
            RD_LOAD: begin
               r_out   <= r_res;
               r_cnt   <= '0;
               r_state <= RD;
            end
            RD:
               if (rready) begin
                  r_out <= {r_out[BLOCK_W-DATA_W-1:0], {DATA_W{1'b0}}};
                  r_cnt <= w_cnt_nxt;
                  if (w_last) begin
                     r_res_valid <= 1'b0;
                     r_state     <= IDLE;
                  end
               end
            default: r_state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_aes_host_if.sv
// tb_aes_host_if: scoreboard bench driving three widths of aes_host_if through write, launch, read and reset scenarios
module tb_aes_host_if;
   localparam logic [127:0] K  = 128'h000102030405060708090A0B0C0D0E0F;
   localparam logic [127:0] R  = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;
   localparam logic [127:0] M  = 128'h00112233445566778899AABBCCDDEEFF;
   localparam logic [127:0] M2 = 128'hFEDCBA98765432100123456789ABCDEF;
   localparam logic [127:0] R2 = 128'h3925841D02DC09FBDC118597196A0B32;

   logic clk = 0, reset = 1, req = 0, rw = 0, addr = 0, wvalid = 0, rready = 0, core_done = 0;
   logic [63:0] wd = '0;
   logic [127:0] core_result = '0;
   int sel = 0, dw = 32, nb = 4;
   int errors = 0, checks = 0;
   logic [63:0] q[$];

   logic [2:0] req_v;
   logic wready_v[3], rvalid_v[3], busy_v[3], err_v[3], kv_v[3], cs_v[3];
   logic [127:0] cm_v[3], ck_v[3];
   logic [63:0] rd_v[3];
   logic [31:0] rd32;
   logic [7:0] rd8;
   logic [63:0] rd64;

   assign req_v = {req && sel == 2, req && sel == 1, req && sel == 0};
   assign rd_v[0] = {32'b0, rd32};
   assign rd_v[1] = {56'b0, rd8};
   assign rd_v[2] = rd64;

   always #5 clk = ~clk;

   aes_host_if #(.DATA_W(32)) u32 (.clk(clk), .reset(reset), .req(req_v[0]), .rw(rw), .addr(addr),
      .wdata(wd[31:0]), .wvalid(wvalid), .wready(wready_v[0]), .rdata(rd32), .rvalid(rvalid_v[0]),
      .rready(rready), .busy(busy_v[0]), .err(err_v[0]), .key_valid(kv_v[0]), .core_msg(cm_v[0]),
      .core_key(ck_v[0]), .core_start(cs_v[0]), .core_done(core_done), .core_result(core_result));
   aes_host_if #(.DATA_W(8)) u8 (.clk(clk), .reset(reset), .req(req_v[1]), .rw(rw), .addr(addr),
      .wdata(wd[7:0]), .wvalid(wvalid), .wready(wready_v[1]), .rdata(rd8), .rvalid(rvalid_v[1]),
      .rready(rready), .busy(busy_v[1]), .err(err_v[1]), .key_valid(kv_v[1]), .core_msg(cm_v[1]),
      .core_key(ck_v[1]), .core_start(cs_v[1]), .core_done(core_done), .core_result(core_result));
   aes_host_if #(.DATA_W(64)) u64 (.clk(clk), .reset(reset), .req(req_v[2]), .rw(rw), .addr(addr),
      .wdata(wd), .wvalid(wvalid), .wready(wready_v[2]), .rdata(rd64), .rvalid(rvalid_v[2]),
      .rready(rready), .busy(busy_v[2]), .err(err_v[2]), .key_valid(kv_v[2]), .core_msg(cm_v[2]),
      .core_key(ck_v[2]), .core_start(cs_v[2]), .core_done(core_done), .core_result(core_result));

   function automatic logic [63:0] word(input logic [127:0] blk, input int i);
      logic [127:0] t;
      t = blk >> (128 - (i + 1) * dw);
      return t[63:0] & ((64'h1 << dw) - 64'h1);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic select(input int s);
      sel = s;
      dw = s == 0 ? 32 : s == 1 ? 8 : 64;
      nb = 128 / dw;
   endtask

   task automatic chk_idle_outputs(input string name);
      logic [69:0] v;
      v = {wready_v[sel], rvalid_v[sel], cs_v[sel], err_v[sel], busy_v[sel], kv_v[sel], rd_v[sel]};
      checks++;
      if (v !== '0) begin
         errors++;
         $display("FAIL %s: outputs {wready,rvalid,start,err,busy,key_valid,rdata}=%h expected 0", name, v);
      end
   endtask

   task automatic do_reset();
      reset = 1;
      step();
      reset = 0;
      step();
   endtask

   task automatic test_reset();
      step();
      chk_idle_outputs("reset_state");
      reset = 0;
      step();
      chk_idle_outputs("after_reset_release");
   endtask

   task automatic test_read_noresult(input string name);
      req = 1; rw = 0;
      step();
      req = 0;
      checks++;
      if (err_v[sel] !== 1'b1 || busy_v[sel] !== 1'b0 || rvalid_v[sel] !== 1'b0) begin
         errors++;
         $display("FAIL %s_err: err/busy/rvalid=%b%b%b expected 100", name, err_v[sel], busy_v[sel], rvalid_v[sel]);
      end
      step();
      checks++;
      if (err_v[sel] !== 1'b0 || busy_v[sel] !== 1'b0) begin
         errors++;
         $display("FAIL %s_err_pulse: err/busy=%b%b expected 00", name, err_v[sel], busy_v[sel]);
      end
   endtask

   task automatic write_blk(input logic a, input logic [127:0] blk, input int stall_at, input int stall_len);
      req = 1; rw = 1; addr = a;
      step();
      req = 0;
      checks++;
      if (wready_v[sel] !== 1'b1 || busy_v[sel] !== 1'b1) begin
         errors++;
         $display("FAIL write_entry: wready/busy=%b%b expected 11", wready_v[sel], busy_v[sel]);
      end
      for (int i = 0; i < nb; i++) begin
         if (i == stall_at) begin
            wvalid = 0;
            repeat (stall_len) step();
            checks++;
            if (wready_v[sel] !== 1'b1 || cs_v[sel] !== 1'b0) begin
               errors++;
               $display("FAIL write_stall: wready/start=%b%b expected 10", wready_v[sel], cs_v[sel]);
            end
         end
         wd = word(blk, i);
         wvalid = 1;
         step();
         wvalid = 0;
      end
   endtask

   task automatic finish_core(input logic [127:0] res);
      checks++;
      if (busy_v[sel] !== 1'b1) begin
         errors++;
         $display("FAIL run_busy: busy=%b expected 1", busy_v[sel]);
      end
      core_result = res;
      core_done = 1;
      for (int i = 0; i < nb; i++) q.push_back(word(res, i));
      step();
      core_done = 0;
      step();
      checks++;
      if (busy_v[sel] !== 1'b0 || cs_v[sel] !== 1'b0) begin
         errors++;
         $display("FAIL run_done: busy/start=%b%b expected 00", busy_v[sel], cs_v[sel]);
      end
   endtask

   task automatic read_blk(input int stall_beat, input int stall_len);
      int idx, guard;
      logic [63:0] exp;
      req = 1; rw = 0;
      step();
      req = 0;
      checks++;
      if (rvalid_v[sel] !== 1'b0 || busy_v[sel] !== 1'b1) begin
         errors++;
         $display("FAIL read_load: rvalid/busy=%b%b expected 01", rvalid_v[sel], busy_v[sel]);
      end
      step();
      idx = 0;
      guard = 0;
      while (q.size() > 0 && guard < 64) begin
         guard++;
         exp = q[0];
         if (idx == stall_beat) begin
            rready = 0;
            repeat (stall_len) begin
               step();
               checks++;
               if (rvalid_v[sel] !== 1'b1 || rd_v[sel] !== exp) begin
                  errors++;
                  $display("FAIL read_stall: rvalid=%b rdata=%h expected 1 %h", rvalid_v[sel], rd_v[sel], exp);
               end
            end
         end
         checks++;
         if (rvalid_v[sel] !== 1'b1 || rd_v[sel] !== exp) begin
            errors++;
            $display("FAIL read_beat%0d: rvalid=%b rdata=%h expected 1 %h", idx, rvalid_v[sel], rd_v[sel], exp);
         end
         rready = 1;
         step();
         rready = 0;
         void'(q.pop_front());
         idx++;
      end
      checks++;
      if (rvalid_v[sel] !== 1'b0 || busy_v[sel] !== 1'b0) begin
         errors++;
         $display("FAIL read_end: rvalid/busy=%b%b expected 00", rvalid_v[sel], busy_v[sel]);
      end
   endtask

   task automatic test_key_load();
      write_blk(1'b1, K, -1, 0);
      checks++;
      if (kv_v[sel] !== 1'b1 || ck_v[sel] !== K || cs_v[sel] !== 1'b0) begin
         errors++;
         $display("FAIL key_load: key_valid=%b core_key=%h start=%b expected 1 %h 0", kv_v[sel], ck_v[sel], cs_v[sel], K);
      end
      step();
      checks++;
      if (cs_v[sel] !== 1'b0 || busy_v[sel] !== 1'b0) begin
         errors++;
         $display("FAIL key_no_start: start/busy=%b%b expected 00", cs_v[sel], busy_v[sel]);
      end
   endtask

   task automatic test_msg_after_key(input logic [127:0] msg, input int wstall, input int rstall);
      write_blk(1'b0, msg, wstall, 3);
      checks++;
      if (cs_v[sel] !== 1'b1 || busy_v[sel] !== 1'b1 || cm_v[sel] !== msg || ck_v[sel] !== K) begin
         errors++;
         $display("FAIL msg_start: start=%b busy=%b msg=%h key=%h expected 1 1 %h %h", cs_v[sel], busy_v[sel], cm_v[sel], ck_v[sel], msg, K);
      end
      step();
      checks++;
      if (cs_v[sel] !== 1'b0 || busy_v[sel] !== 1'b1 || cm_v[sel] !== msg) begin
         errors++;
         $display("FAIL msg_start_once: start=%b busy=%b msg=%h expected 0 1 %h", cs_v[sel], busy_v[sel], cm_v[sel], msg);
      end
      finish_core(R);
      read_blk(rstall, 2);
      test_read_noresult("res_cleared");
   endtask

   task automatic test_msg_before_key();
      do_reset();
      write_blk(1'b0, M, -1, 0);
      step();
      checks++;
      if (cs_v[sel] !== 1'b0 || busy_v[sel] !== 1'b0) begin
         errors++;
         $display("FAIL nokey_no_start: start/busy=%b%b expected 00", cs_v[sel], busy_v[sel]);
      end
      write_blk(1'b1, K, -1, 0);
      checks++;
      if (cs_v[sel] !== 1'b0 || busy_v[sel] !== 1'b0) begin
         errors++;
         $display("FAIL key_done_idle: start/busy=%b%b expected 00", cs_v[sel], busy_v[sel]);
      end
      step();
      checks++;
      if (cs_v[sel] !== 1'b1 || busy_v[sel] !== 1'b1 || cm_v[sel] !== M) begin
         errors++;
         $display("FAIL late_launch: start=%b busy=%b msg=%h expected 1 1 %h", cs_v[sel], busy_v[sel], cm_v[sel], M);
      end
      step();
      finish_core(R2);
      read_blk(-1, 0);
      write_blk(1'b0, M2, -1, 0);
      checks++;
      if (cs_v[sel] !== 1'b1 || cm_v[sel] !== M2 || ck_v[sel] !== K) begin
         errors++;
         $display("FAIL key_reuse: start=%b msg=%h key=%h expected 1 %h %h", cs_v[sel], cm_v[sel], ck_v[sel], M2, K);
      end
      step();
      finish_core(R);
      read_blk(-1, 0);
   endtask

   task automatic test_reset_mid();
      do_reset();
      test_key_load();
      req = 1; rw = 1; addr = 0;
      step();
      req = 0;
      for (int i = 0; i < 2; i++) begin
         wd = word(M, i); wvalid = 1;
         step();
      end
      wd = word(M, 2);
      #2 reset = 1;
      #1 chk_idle_outputs("reset_in_write");
      step();
      wvalid = 0;
      reset = 0;
      step();
      test_key_load();
      step();
      checks++;
      if (cs_v[sel] !== 1'b0 || busy_v[sel] !== 1'b0) begin
         errors++;
         $display("FAIL msg_discarded: start/busy=%b%b expected 00", cs_v[sel], busy_v[sel]);
      end
      write_blk(1'b0, M, -1, 0);
      #2 reset = 1;
      #1 chk_idle_outputs("reset_in_run");
      step();
      reset = 0;
      core_result = R;
      core_done = 1;
      step();
      core_done = 0;
      chk_idle_outputs("done_ignored");
      test_read_noresult("done_ignored");
   endtask

   initial begin
      select(0);
      test_reset();
      test_read_noresult("no_result");
      test_key_load();
      test_msg_after_key(M, -1, -1);
      test_msg_after_key(M2, 2, 1);
      test_msg_before_key();
      test_reset_mid();
      for (int s = 1; s < 3; s++) begin
         select(s);
         do_reset();
         test_key_load();
         test_msg_after_key(M, 1, 1);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
